// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared encodings for the multi-cycle MIPS-subset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    localparam int ALU_OP_LENGTH  = 3;
    localparam int REG_DST_LENGTH = 2;
    localparam int REG_SRC_LENGTH = 3;
    localparam int EXT_OP_LENGTH  = 2;
    localparam int NPC_OP_LENGTH  = 2;

    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_DEFAULT = 3'd0;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD     = 3'd1;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB     = 3'd2;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR      = 3'd3;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND     = 3'd4;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_XOR     = 3'd5;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLL     = 3'd6;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRL     = 3'd7;

    localparam logic [REG_DST_LENGTH-1:0] REG_DST_DEFAULT = 2'd0;
    localparam logic [REG_DST_LENGTH-1:0] REG_DST_RD      = 2'd1;
    localparam logic [REG_DST_LENGTH-1:0] REG_DST_RT      = 2'd2;
    localparam logic [REG_DST_LENGTH-1:0] REG_DST_REG_31  = 2'd3;

    localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_DEFAULT = 3'd0;
    localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_ALU     = 3'd1;
    localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM     = 3'd2;
    localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_IMM     = 3'd3;
    localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_JMP_DST = 3'd4;

    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_DEFAULT  = 2'd0;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_UNSIGNED = 2'd1;
    localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SIGNED   = 2'd2;

    localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_DEFAULT = 2'd0;
    localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_NEXT    = 2'd1;
    localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_OFFSET  = 2'd2;
    localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JUMP    = 2'd3;

    localparam logic [5:0] INST_RTYPE = 6'h00;
    localparam logic [5:0] INST_J     = 6'h02;
    localparam logic [5:0] INST_JAL   = 6'h03;
    localparam logic [5:0] INST_BEQ   = 6'h04;
    localparam logic [5:0] INST_ADDI  = 6'h08;
    localparam logic [5:0] INST_ADDIU = 6'h09;
    localparam logic [5:0] INST_ORI   = 6'h0D;
    localparam logic [5:0] INST_LUI   = 6'h0F;
    localparam logic [5:0] INST_LW    = 6'h23;
    localparam logic [5:0] INST_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef struct packed {
        logic r_alu;
        logic i_alu;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : IR fields, memory handshake and datapath controls of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [5:0]                opcode;
    logic [5:0]                func;
    logic                      zero;
    logic                      mem_ready;
    logic                      mem_req;
    logic                      mem_we;
    logic                      iord;
    logic                      ir_write;
    logic                      pc_write;
    logic [NPC_OP_LENGTH-1:0]  npc_op;
    logic [ALU_OP_LENGTH-1:0]  alu_op;
    logic                      alu_src;
    logic [EXT_OP_LENGTH-1:0]  ext_op;
    logic                      reg_write;
    logic [REG_DST_LENGTH-1:0] reg_dst;
    logic [REG_SRC_LENGTH-1:0] reg_src;
    logic [2:0]                state;
    logic                      retire;

    modport master (
        input  opcode, func, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, npc_op, alu_op,
               alu_src, ext_op, reg_write, reg_dst, reg_src, state, retire
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, npc_op, alu_op,
               alu_src, ext_op, reg_write, reg_dst, reg_src, state, retire
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_inst_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : inst_class_decode
// Description : Maps opcode/func to one-hot instruction classes plus alu_op/ext_op.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  wire logic [5:0]               opcode_i,
    input  wire logic [5:0]               func_i,
    output inst_class_t                   cls_o,
    output logic [ALU_OP_LENGTH-1:0]      alu_op_o,
    output logic [EXT_OP_LENGTH-1:0]      ext_op_o
);

    always_comb begin
        cls_o    = '0;
        alu_op_o = ALU_OP_DEFAULT;
        ext_op_o = EXT_OP_DEFAULT;
        case (opcode_i)
            INST_RTYPE: begin
                cls_o.r_alu = 1'b1;
                case (func_i)
                    FUNC_ADD, FUNC_ADDU:           alu_op_o = ALU_OP_ADD;
                    FUNC_SUB, FUNC_SUBU, FUNC_SLT: alu_op_o = ALU_OP_SUB;
                    FUNC_AND:                      alu_op_o = ALU_OP_AND;
                    FUNC_OR:                       alu_op_o = ALU_OP_OR;
                    FUNC_XOR:                      alu_op_o = ALU_OP_XOR;
                    FUNC_SLL:                      alu_op_o = ALU_OP_SLL;
                    FUNC_SRL:                      alu_op_o = ALU_OP_SRL;
                    default: begin
                        cls_o.r_alu   = 1'b0;
                        cls_o.illegal = 1'b1;
                    end
                endcase
            end
            INST_ADDI, INST_ADDIU: begin
                cls_o.i_alu = 1'b1;
                alu_op_o    = ALU_OP_ADD;
                ext_op_o    = EXT_OP_SIGNED;
            end
            INST_ORI: begin
                cls_o.i_alu = 1'b1;
                alu_op_o    = ALU_OP_OR;
                ext_op_o    = EXT_OP_UNSIGNED;
            end
            INST_LUI: cls_o.lui = 1'b1;
            INST_LW: begin
                cls_o.lw = 1'b1;
                alu_op_o = ALU_OP_ADD;
                ext_op_o = EXT_OP_UNSIGNED;
            end
            INST_SW: begin
                cls_o.sw = 1'b1;
                alu_op_o = ALU_OP_ADD;
                ext_op_o = EXT_OP_UNSIGNED;
            end
            INST_BEQ: begin
                cls_o.beq = 1'b1;
                alu_op_o  = ALU_OP_SUB;
            end
            INST_J:   cls_o.j   = 1'b1;
            INST_JAL: cls_o.jal = 1'b1;
            default:  cls_o.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready memory port.
//               Define ILLEGAL_INST_TRAP_EN to trap undefined instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    multicycle_ctrl_if.master  bus
);

    state_e                    state_q;
    state_e                    state_d;
    inst_class_t               cls;
    logic [ALU_OP_LENGTH-1:0]  dec_alu_op;
    logic [EXT_OP_LENGTH-1:0]  dec_ext_op;

    logic                      mem_req;
    logic                      mem_we;
    logic                      iord;
    logic                      ir_write;
    logic                      pc_write;
    logic [NPC_OP_LENGTH-1:0]  npc_op;
    logic [ALU_OP_LENGTH-1:0]  alu_op;
    logic                      alu_src;
    logic [EXT_OP_LENGTH-1:0]  ext_op;
    logic                      reg_write;
    logic [REG_DST_LENGTH-1:0] reg_dst;
    logic [REG_SRC_LENGTH-1:0] reg_src;
    logic                      retire;

    inst_class_decode u_decode (
        .opcode_i (bus.opcode),
        .func_i   (bus.func),
        .cls_o    (cls),
        .alu_op_o (dec_alu_op),
        .ext_op_o (dec_ext_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        npc_op    = NPC_OP_DEFAULT;
        alu_op    = ALU_OP_DEFAULT;
        alu_src   = 1'b0;
        ext_op    = EXT_OP_DEFAULT;
        reg_write = 1'b0;
        reg_dst   = REG_DST_DEFAULT;
        reg_src   = REG_SRC_DEFAULT;
        retire    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    npc_op   = NPC_OP_NEXT;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls.j || cls.jal) begin
                    pc_write = 1'b1;
                    npc_op   = NPC_OP_JUMP;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                    // PC already holds PC+4 from FETCH, which is the link value
                    if (cls.jal) begin
                        reg_write = 1'b1;
                        reg_dst   = REG_DST_REG_31;
                        reg_src   = REG_SRC_JMP_DST;
                    end
                end else if (cls.lui) begin
                    state_d = ST_WB;
                end else if (cls.illegal) begin
`ifdef ILLEGAL_INST_TRAP_EN
                    state_d = ST_TRAP;
`else
                    retire  = 1'b1;
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = dec_alu_op;
                ext_op  = dec_ext_op;
                alu_src = cls.i_alu | cls.lw | cls.sw;
                if (cls.beq) begin
                    if (bus.zero) begin
                        pc_write = 1'b1;
                        npc_op   = NPC_OP_OFFSET;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = cls.sw;
                if (bus.mem_ready) begin
                    if (cls.sw) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                reg_dst   = cls.r_alu ? REG_DST_RD : REG_DST_RT;
                if (cls.lw) begin
                    reg_src = REG_SRC_MEM;
                end else if (cls.lui) begin
                    reg_src = REG_SRC_IMM;
                end else begin
                    reg_src = REG_SRC_ALU;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef ILLEGAL_INST_TRAP_EN
                state_d = ST_TRAP;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset kills every strobe, including a request already in flight
        if (!rst_n) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.iord      = iord;
    assign bus.ir_write  = ir_write;
    assign bus.pc_write  = pc_write;
    assign bus.npc_op    = npc_op;
    assign bus.alu_op    = alu_op;
    assign bus.alu_src   = alu_src;
    assign bus.ext_op    = ext_op;
    assign bus.reg_write = reg_write;
    assign bus.reg_dst   = reg_dst;
    assign bus.reg_src   = reg_src;
    assign bus.state     = state_q;
    assign bus.retire    = retire;

endmodule
`default_nettype wire
